falc_mux_bus_ctrl: RTL

Parametrised host-side controller for the FALC56 multiplexed address/data microprocessor bus. It turns single-beat host read/write requests into ALE/CSn/RDn/WRn cycles with programmable phase timing. It supports NUM_CS framer devices and synchronises their interrupt lines. It sits between the register-access fabric and the FALC56 pad wrapper, and drives the wrapper's BADD/ALE/RDn/WRn/CSn/DIR inputs.

---
 rtl/falc_bus_pkg.sv | 16 +
 rtl/falc_int_sync.sv | 39 +++
 rtl/falc_mux_bus_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/falc_bus_pkg.sv
// rtl/falc_bus_pkg.sv - shared types and widths for the FALC56 mux-bus controller
package falc_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_AHOLD,
      ST_STROBE,
      ST_RSP,
      ST_RECOV
   } state_t;

   localparam int CNT_W = 4;
   localparam int CS_W  = 3;

endpackage

// File: rtl/falc_int_sync.sv
// rtl/falc_int_sync.sv - per-line interrupt synchroniser with polarity fix-up and rise detect
module falc_int_sync #(
   parameter int NUM_CS      = 2,
   parameter int INT_ACT_LOW = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NUM_CS-1:0] i_int,
   output logic [NUM_CS-1:0] o_int,
   output logic [NUM_CS-1:0] o_int_rise
);

   logic [NUM_CS-1:0] r_meta;
   logic [NUM_CS-1:0] r_sync;
   logic [NUM_CS-1:0] r_sync_d1;
   logic              r_primed;
   logic [NUM_CS-1:0] w_meta_pol;

   assign w_meta_pol = (INT_ACT_LOW != 0) ? ~r_meta : r_meta;

   // r_primed keeps the cleared first stage from looking like an asserted active-low pin right after reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta    <= '0;
         r_sync    <= '0;
         r_sync_d1 <= '0;
         r_primed  <= 1'b0;
      end else begin
         r_meta    <= i_int;
         r_primed  <= 1'b1;
         r_sync    <= r_primed ? w_meta_pol : '0;
         r_sync_d1 <= r_sync;
      end
   end

   assign o_int      = r_sync;
   assign o_int_rise = r_sync & ~r_sync_d1;

endmodule

// File: rtl/falc_mux_bus_ctrl.sv
// rtl/falc_mux_bus_ctrl.sv - host request to FALC56 ALE/CSn/RDn/WRn multiplexed bus sequencer
module falc_mux_bus_ctrl
   import falc_bus_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int NUM_CS      = 2,
   parameter int T_ALE       = 2,
   parameter int T_AH        = 1,
   parameter int T_STB       = 4,
   parameter int T_REC       = 2,
   parameter int INT_ACT_LOW = 1
) (
   input  logic              CLK_I,
   input  logic              RST_I,
   input  logic              REQ_VALID_I,
   output logic              REQ_READY_O,
   input  logic              REQ_WR_I,
   input  logic [2:0]        REQ_CS_I,
   input  logic [DATA_W-1:0] REQ_ADDR_I,
   input  logic [DATA_W-1:0] REQ_WDATA_I,
   output logic              RSP_VALID_O,
   output logic [DATA_W-1:0] RSP_RDATA_O,
   output logic              RSP_ERR_O,
   output logic [DATA_W-1:0] BADD_O,
   input  logic [DATA_W-1:0] BADD_I,
   output logic              BADD_DIR_O,
   output logic              ALE_O,
   output logic              RDn_O,
   output logic              WRn_O,
   output logic [NUM_CS-1:0] CSn_O,
   input  logic [NUM_CS-1:0] INT_I,
   output logic [NUM_CS-1:0] INT_O,
   output logic [NUM_CS-1:0] INT_RISE_O
);

   localparam logic [CNT_W-1:0] C_ALE = CNT_W'(T_ALE - 1);
   localparam logic [CNT_W-1:0] C_AH  = CNT_W'(T_AH - 1);
   localparam logic [CNT_W-1:0] C_STB = CNT_W'(T_STB - 1);
   localparam logic [CNT_W-1:0] C_REC = CNT_W'(T_REC - 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_wr;
   logic [CS_W-1:0]   r_cs;
   logic [DATA_W-1:0] r_wdata;
   logic              r_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic [DATA_W-1:0] r_badd;
   logic              r_dir;
   logic              r_ale;
   logic              r_rdn;
   logic              r_wrn;
   logic [NUM_CS-1:0] r_csn;

   logic              w_accept;
   logic              w_cs_ok;
   logic [NUM_CS-1:0] w_csn_sel;

   assign w_accept = REQ_VALID_I & r_ready;
   assign w_cs_ok  = int'(r_cs) < NUM_CS;

   // An out-of-range index matches no bit, so the cycle runs with every chip select parked high.
   always_comb begin
      w_csn_sel = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         w_csn_sel[i] = ~(r_cs == CS_W'(i));
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_wr        <= 1'b0;
         r_cs        <= '0;
         r_wdata     <= '0;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_badd      <= '0;
         r_dir       <= 1'b0;
         r_ale       <= 1'b0;
         r_rdn       <= 1'b1;
         r_wrn       <= 1'b1;
         r_csn       <= '1;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_ready <= 1'b0;
                  r_wr    <= REQ_WR_I;
                  r_cs    <= REQ_CS_I;
                  r_wdata <= REQ_WDATA_I;
                  r_badd  <= REQ_ADDR_I;
                  r_dir   <= 1'b1;
                  r_ale   <= 1'b1;
                  r_cnt   <= C_ALE;
                  r_state <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (r_cnt == '0) begin
                  r_ale   <= 1'b0;
                  r_cnt   <= C_AH;
                  r_state <= ST_AHOLD;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_AHOLD: begin
               if (r_cnt == '0) begin
                  r_csn   <= w_csn_sel;
                  r_cnt   <= C_STB;
                  r_state <= ST_STROBE;
                  if (r_wr) begin
                     r_wrn  <= 1'b0;
                     r_badd <= r_wdata;
                  end else begin
                     r_rdn <= 1'b0;
                     r_dir <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_STROBE: begin
               if (r_cnt == '0) begin
                  r_rdn       <= 1'b1;
                  r_wrn       <= 1'b1;
                  r_csn       <= '1;
                  r_dir       <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= ~w_cs_ok;
                  r_rsp_rdata <= (!r_wr && w_cs_ok) ? BADD_I : '0;
                  r_state     <= ST_RSP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_RSP: begin
               r_cnt   <= C_REC;
               r_state <= ST_RECOV;
            end
            ST_RECOV: begin
               if (r_cnt == '0) begin
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign REQ_READY_O = r_ready;
   assign RSP_VALID_O = r_rsp_valid;
   assign RSP_RDATA_O = r_rsp_rdata;
   assign RSP_ERR_O   = r_rsp_err;
   assign BADD_O      = r_badd;
   assign BADD_DIR_O  = r_dir;
   assign ALE_O       = r_ale;
   assign RDn_O       = r_rdn;
   assign WRn_O       = r_wrn;
   assign CSn_O       = r_csn;

   falc_int_sync #(
      .NUM_CS      (NUM_CS),
      .INT_ACT_LOW (INT_ACT_LOW)
   ) u_int_sync (
      .i_clk      (CLK_I),
      .i_rst      (RST_I),
      .i_int      (INT_I),
      .o_int      (INT_O),
      .o_int_rise (INT_RISE_O)
   );

endmodule
